// File: rtl/serial_scb_adder_ctrl_pkg.sv
// Shared constants for the serial wide-adder sequencer.
//   CHUNK_W : bits consumed per cycle by the 4-bit adder slice
//   ST_*    : FSM state encodings (IDLE -> RUN -> DONE -> IDLE)
package adder_ctrl_pkg;
  localparam int         CHUNK_W = 4;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/scb_cla4.sv
// 4-bit square-root carry-select adder slice.
// The low 2 bits ripple from the carry-in. The high 2 bits are computed
// twice, once for each possible carry, and the ripple carry from the low
// half picks one of the two.
//   i_x, i_y : 4-bit addends
//   i_cin    : carry-in
//   o_s      : 4-bit sum
//   o_cout   : carry-out
module scb_cla4 (
  input  logic [3:0] i_x,
  input  logic [3:0] i_y,
  input  logic       i_cin,
  output logic [3:0] o_s,
  output logic       o_cout
);
  logic [3:0] w_g, w_p;
  logic       w_c1, w_c2;
  logic       w_c3_0, w_c3_1;
  logic [1:0] w_hi_0, w_hi_1;
  logic       w_co_0, w_co_1;

  assign w_g = i_x & i_y;
  assign w_p = i_x ^ i_y;

  // low half: plain ripple
  assign w_c1 = w_g[0] | (w_p[0] & i_cin);
  assign w_c2 = w_g[1] | (w_p[1] & w_c1);

  // high half, one copy assuming carry 0 and one assuming carry 1
  assign w_c3_0 = w_g[2];
  assign w_c3_1 = w_g[2] | w_p[2];
  assign w_hi_0 = {w_p[3] ^ w_c3_0, w_p[2]};
  assign w_hi_1 = {w_p[3] ^ w_c3_1, ~w_p[2]};
  assign w_co_0 = w_g[3] | (w_p[3] & w_c3_0);
  assign w_co_1 = w_g[3] | (w_p[3] & w_c3_1);

  assign o_s    = {(w_c2 ? w_hi_1 : w_hi_0), w_p[1] ^ w_c1, w_p[0] ^ i_cin};
  assign o_cout = w_c2 ? w_co_1 : w_co_0;
endmodule

// File: rtl/serial_scb_adder_ctrl.sv
// Multi-cycle WIDTH-bit adder that reuses a single 4-bit slice.
// Operands are captured on an in_valid/in_ready handshake, added one 4-bit
// chunk per cycle starting at the LSB chunk, and the result is held on
// out_valid until out_ready.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (ready only in IDLE)
//   a, b, cin           : operands and carry-in
//   out_valid/out_ready : result handshake (valid only in DONE)
//   sum, cout           : registered result {cout,sum} = a+b+cin
//   busy                : high in RUN or DONE
module serial_scb_adder_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int NCHUNK = WIDTH / CHUNK_W;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NCHUNK - 1);

  if (WIDTH < CHUNK_W || (WIDTH % CHUNK_W) != 0) begin : g_bad_width
    $error("serial_scb_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
  end

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_a_sh, r_b_sh, r_sum;
  logic               r_c, r_cout;
  logic [CW-1:0]      r_cnt;

  logic [CHUNK_W-1:0] w_s;
  logic               w_co;
  // slice result prepended above the current sum; the top WIDTH bits are
  // the sum shifted right by one chunk (also valid when WIDTH == 4)
  logic [WIDTH+CHUNK_W-1:0] w_sum_ext;

  scb_cla4 u_slice (
    .i_x    (r_a_sh[CHUNK_W-1:0]),
    .i_y    (r_b_sh[CHUNK_W-1:0]),
    .i_cin  (r_c),
    .o_s    (w_s),
    .o_cout (w_co)
  );

  assign w_sum_ext = {w_s, r_sum};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_sum   <= '0;
      r_c     <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (in_valid) begin
          r_a_sh  <= a;
          r_b_sh  <= b;
          r_c     <= cin;
          r_cnt   <= '0;
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          r_a_sh <= r_a_sh >> CHUNK_W;
          r_b_sh <= r_b_sh >> CHUNK_W;
          r_sum  <= w_sum_ext[WIDTH+CHUNK_W-1:CHUNK_W];
          r_c    <= w_co;
          // counter stops at the last chunk rather than wrapping
          if (r_cnt == CNT_LAST) begin
            r_cout  <= w_co;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: if (out_ready) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state == ST_RUN) || (r_state == ST_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
endmodule

// File: tb/tb_serial_scb_adder_ctrl.sv
module tb_serial_scb_adder_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [31:0] a, b, sum;
  // WIDTH=4 instance
  logic        in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4, busy4;
  logic [3:0]  a4, b4, sum4;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_scb_adder_ctrl #(.WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  serial_scb_adder_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4), .busy(busy4)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  // stimulus only: launch one op and count edges until out_valid
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_, input logic tc,
                       output int lat);
    a = ta; b = tb_; cin = tc; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 30) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if ({cout, sum} !== 33'h0) begin bad++; $display("FAIL reset_sum got=%h exp=0", {cout, sum}); end
  endtask

  task automatic test_basic();
    int lat;
    do_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, lat);
    total++; if (lat != 8) begin bad++; $display("FAIL basic1_latency got=%0d exp=8", lat); end
    total++; if ({cout, sum} !== {1'b1, 32'h0}) begin bad++; $display("FAIL basic1_sum got=%h exp=100000000", {cout, sum}); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL basic1_release in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid); end
    do_op(32'h1234_5678, 32'h8765_4321, 1'b1, lat);
    total++; if (lat != 8) begin bad++; $display("FAIL basic2_latency got=%0d exp=8", lat); end
    total++; if ({cout, sum} !== {1'b0, 32'h9999_999A}) begin bad++; $display("FAIL basic2_sum got=%h exp=09999999a", {cout, sum}); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat;
    do_op(32'h0F0F_0F0F, 32'h1111_1111, 1'b0, lat);
    total++; if (lat != 8) begin bad++; $display("FAIL bp_latency got=%0d exp=8", lat); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom; cin = 1'b1;
      step();
      total++;
      if ({cout, sum} !== {1'b0, 32'h2020_2020} || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d sum=%h in_ready=%b out_valid=%b exp 020202020/0/1", i, {cout, sum}, in_ready, out_valid);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL bp_release in_ready=%b out_valid=%b busy=%b exp 1/0/0", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; cin = 1'b0; in_valid = 1'b1;
    step();                 // accept edge
    in_valid = 1'b0;
    step(); step();         // now in the third RUN cycle
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || {cout, sum} !== 33'h0) begin
      bad++;
      $display("FAIL midreset in_ready=%b out_valid=%b busy=%b sum=%h exp 1/0/0/0", in_ready, out_valid, busy, {cout, sum});
    end
    do_op(32'd5, 32'd7, 1'b0, lat);
    total++; if (lat != 8) begin bad++; $display("FAIL midreset_op_latency got=%0d exp=8", lat); end
    total++; if ({cout, sum} !== 33'd12) begin bad++; $display("FAIL midreset_op_sum got=%h exp=00000000c", {cout, sum}); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_throughput();
    int t[3];
    int n = 0;
    int guard = 0;
    out_ready = 1'b1; in_valid = 1'b1;
    a = 32'hDEAD_BEEF; b = 32'h0123_4567; cin = 1'b0;
    while (n < 3 && guard < 60) begin
      if (in_ready) begin t[n] = cyc; n++; end
      step();
      guard++;
    end
    in_valid = 1'b0;
    total++;
    if (n != 3) begin bad++; $display("FAIL thru_accepts got=%0d exp=3", n); end
    else begin
      total++; if (t[1] - t[0] != 10) begin bad++; $display("FAIL thru_period01 got=%0d exp=10", t[1] - t[0]); end
      total++; if (t[2] - t[1] != 10) begin bad++; $display("FAIL thru_period12 got=%0d exp=10", t[2] - t[1]); end
    end
    guard = 0;
    while (busy && guard < 30) begin step(); guard++; end
    out_ready = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL thru_drain busy=%b exp=0", busy); end
  endtask

  task automatic test_random();
    logic [32:0] q[$];
    logic [32:0] e;
    int issued = 0, got = 0, guard = 0;
    while ((issued < 1000 || q.size() > 0) && guard < 60000) begin
      in_valid  = (issued < 1000) && ($urandom_range(0, 3) != 0);
      a         = $urandom;
      b         = $urandom;
      cin       = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      if (in_valid && in_ready) begin
        q.push_back({1'b0, a} + {1'b0, b} + {32'd0, cin});
        issued++;
      end
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rand_extra_result got=%h", {cout, sum});
        end else begin
          e = q.pop_front();
          if ({cout, sum} !== e) begin bad++; $display("FAIL rand_sum n=%0d got=%h exp=%h", got, {cout, sum}, e); end
        end
        got++;
      end
      step();
      guard++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    total++; if (got != 1000) begin bad++; $display("FAIL rand_count got=%0d exp=1000", got); end
  endtask

  task automatic test_width4();
    a4 = 4'hF; b4 = 4'h1; cin4 = 1'b1; in_valid4 = 1'b1;
    total++; if (in_ready4 !== 1'b1) begin bad++; $display("FAIL w4_ready got=%b exp=1", in_ready4); end
    step();
    in_valid4 = 1'b0;
    step();
    total++;
    if (out_valid4 !== 1'b1 || {cout4, sum4} !== 5'h11) begin
      bad++; $display("FAIL w4_op1 out_valid=%b sum=%h exp 1/11", out_valid4, {cout4, sum4});
    end
    out_ready4 = 1'b1; step(); out_ready4 = 1'b0;
    total++; if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin bad++; $display("FAIL w4_release in_ready=%b out_valid=%b", in_ready4, out_valid4); end
    a4 = 4'h7; b4 = 4'h8; cin4 = 1'b0; in_valid4 = 1'b1;
    step();
    in_valid4 = 1'b0;
    step();
    total++;
    if (out_valid4 !== 1'b1 || {cout4, sum4} !== 5'h0F) begin
      bad++; $display("FAIL w4_op2 out_valid=%b sum=%h exp 1/0f", out_valid4, {cout4, sum4});
    end
    out_ready4 = 1'b1; step(); out_ready4 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    step(); step();
    rst = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid_run();
    test_throughput();
    test_random();
    test_width4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
